// File: rtl/isp_ccm_pkg.sv
// Shared constants and the FIFO word layout for the colour-correction
// round/clamp stage.
package isp_ccm_pkg;

    localparam int PROD_W    = 38;
    localparam int PIX_W     = 10;
    localparam int COEF_FRAC = 10;
    localparam int MULT_LAT  = 2;

    typedef struct packed {
        logic             sof;
        logic             eol;
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } ccm_word_t;

endpackage

// File: rtl/isp_sync_fifo.sv
// Synchronous show-ahead FIFO. Pointers wrap modulo DEPTH, so DEPTH need not
// be a power of two. A push into a full FIFO is dropped even when a pop
// happens in the same cycle.
module isp_sync_fifo #(
    parameter  int W     = 32,
    parameter  int DEPTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_push,
    input  logic [W-1:0]    i_wdata,
    input  logic            i_pop,
    output logic [W-1:0]    o_rdata,
    output logic            o_full,
    output logic            o_empty,
    output logic [CNTW-1:0] o_count
);

    logic [W-1:0]    r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CNTW-1:0] r_count;
    logic            w_wr;
    logic            w_rd;

    function automatic logic [AW-1:0] f_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full  = (r_count == CNTW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];
    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && !o_empty;

    // Storage array; no reset so it maps onto plain registers or RAM.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wdata;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= f_next(r_wr_ptr);
            if (w_rd) r_rd_ptr <= f_next(r_rd_ptr);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ccm_round_clamp.sv
// Round/clamp stage behind the 3x3 CCM multiplier. Tags ride a shift register
// matched to the multiplier latency, products are rounded and clamped into
// pixel range, and results are buffered in a FIFO feeding a valid/ready port.
// The multiplier cannot stall, so in_ready is a credit: it is only high when
// every pixel already in the pipe is guaranteed a FIFO slot.
module ccm_round_clamp #(
    parameter int MULT_LAT  = isp_ccm_pkg::MULT_LAT,
    parameter int FRAC_BITS = isp_ccm_pkg::COEF_FRAC,
    parameter int PROD_W    = isp_ccm_pkg::PROD_W,
    parameter int OUT_W     = isp_ccm_pkg::PIX_W,
    parameter int DEPTH     = 8,
    parameter int SAT_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     px_valid,
    input  logic                     px_sof,
    input  logic                     px_eol,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] iA,
    input  logic signed [PROD_W-1:0] iB,
    input  logic signed [PROD_W-1:0] iC,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [OUT_W-1:0]         oR,
    output logic [OUT_W-1:0]         oG,
    output logic [OUT_W-1:0]         oB,
    output logic                     o_sof,
    output logic                     o_eol,
    output logic [SAT_W-1:0]         sat_cnt,
    output logic                     err_ovf
);

    import isp_ccm_pkg::*;

    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int CW   = $clog2(DEPTH + MULT_LAT + 2) + 1;
    localparam logic [PROD_W:0] RND_HALF = (PROD_W + 1)'(1) << (FRAC_BITS - 1);

    // Result layout: [OUT_W] = clamp flag, [OUT_W-1:0] = pixel value.
    function automatic logic [OUT_W:0] f_round_clamp(input logic signed [PROD_W-1:0] p);
        logic signed [PROD_W:0] s;
        logic signed [PROD_W:0] q;
        s = $signed({p[PROD_W-1], p}) + $signed(RND_HALF);
        q = s >>> FRAC_BITS;
        if (q[PROD_W])
            return {1'b1, {OUT_W{1'b0}}};
        else if (|q[PROD_W-1:OUT_W])
            return {1'b1, {OUT_W{1'b1}}};
        else
            return {1'b0, q[OUT_W-1:0]};
    endfunction

    logic [MULT_LAT-1:0] r_sh_vld;
    logic [MULT_LAT-1:0] r_sh_sof;
    logic [MULT_LAT-1:0] r_sh_eol;

    logic [OUT_W:0]      w_rc_a;
    logic [OUT_W:0]      w_rc_b;
    logic [OUT_W:0]      w_rc_c;

    logic                r_cl_vld;
    logic                r_cl_sof;
    logic                r_cl_eol;
    logic                r_cl_sat;
    logic [OUT_W-1:0]    r_cl_r;
    logic [OUT_W-1:0]    r_cl_g;
    logic [OUT_W-1:0]    r_cl_b;

    ccm_word_t           w_wr_word;
    ccm_word_t           w_rd_word;
    logic                w_full;
    logic                w_empty;
    logic [CNTW-1:0]     w_count;
    logic                w_pop;
    logic [CW-1:0]       w_credit_used;

    logic [SAT_W-1:0]    r_sat_cnt;
    logic                r_err_ovf;

    // Tag pipeline. It follows px_valid directly because the multiplier
    // processes whatever it is given; a source that ignores in_ready will
    // therefore overflow the FIFO, which err_ovf records.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sh_vld <= '0;
            r_sh_sof <= '0;
            r_sh_eol <= '0;
        end else begin
            r_sh_vld[0] <= px_valid;
            r_sh_sof[0] <= px_valid & px_sof;
            r_sh_eol[0] <= px_valid & px_eol;
            for (int i = 1; i < MULT_LAT; i++) begin
                r_sh_vld[i] <= r_sh_vld[i-1];
                r_sh_sof[i] <= r_sh_sof[i-1];
                r_sh_eol[i] <= r_sh_eol[i-1];
            end
        end
    end

    // Per-channel round and clamp of the products aligned with the tag tail.
    always_comb begin
        w_rc_a = f_round_clamp(iA);
        w_rc_b = f_round_clamp(iB);
        w_rc_c = f_round_clamp(iC);
    end

    // Clamp-stage register; its contents are pushed into the FIFO next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cl_vld <= 1'b0;
            r_cl_sof <= 1'b0;
            r_cl_eol <= 1'b0;
            r_cl_sat <= 1'b0;
            r_cl_r   <= '0;
            r_cl_g   <= '0;
            r_cl_b   <= '0;
        end else begin
            r_cl_vld <= r_sh_vld[MULT_LAT-1];
            r_cl_sof <= r_sh_sof[MULT_LAT-1];
            r_cl_eol <= r_sh_eol[MULT_LAT-1];
            r_cl_sat <= w_rc_a[OUT_W] | w_rc_b[OUT_W] | w_rc_c[OUT_W];
            r_cl_r   <= w_rc_a[OUT_W-1:0];
            r_cl_g   <= w_rc_b[OUT_W-1:0];
            r_cl_b   <= w_rc_c[OUT_W-1:0];
        end
    end

    assign w_wr_word = '{sof: r_cl_sof, eol: r_cl_eol, r: r_cl_r, g: r_cl_g, b: r_cl_b};
    assign w_pop     = o_valid && o_ready;

    isp_sync_fifo #(
        .W     ($bits(ccm_word_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (r_cl_vld),
        .i_wdata (w_wr_word),
        .i_pop   (w_pop),
        .o_rdata (w_rd_word),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Credit: slots already owned by stored or in-flight pixels. A pop in the
    // current cycle is deliberately not counted so in_ready has no path from
    // o_ready.
    always_comb begin
        w_credit_used = CW'(w_count) + CW'($countones(r_sh_vld)) + CW'(r_cl_vld);
        in_ready      = (w_credit_used < CW'(DEPTH));
    end

    // Saturation count per frame and sticky overflow, both tracked at write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sat_cnt <= '0;
            r_err_ovf <= 1'b0;
        end else begin
            if (r_cl_vld) begin
                if (r_cl_sof)
                    r_sat_cnt <= SAT_W'(r_cl_sat);
                else if (r_cl_sat && (r_sat_cnt != '1))
                    r_sat_cnt <= r_sat_cnt + 1'b1;
            end
            if (r_cl_vld && w_full) r_err_ovf <= 1'b1;
        end
    end

    // Head of FIFO drives the port; outputs read as zero while empty.
    always_comb begin
        o_valid = !w_empty;
        oR      = o_valid ? w_rd_word.r   : '0;
        oG      = o_valid ? w_rd_word.g   : '0;
        oB      = o_valid ? w_rd_word.b   : '0;
        o_sof   = o_valid ? w_rd_word.sof : 1'b0;
        o_eol   = o_valid ? w_rd_word.eol : 1'b0;
        sat_cnt = r_sat_cnt;
        err_ovf = r_err_ovf;
    end

endmodule

// File: tb/tb_ccm_round_clamp.sv
// Directed bench for ccm_round_clamp with a 2-cycle multiplier model.
module tb_ccm_round_clamp;

    localparam int PW = 38;
    localparam int OW = 10;
    localparam int SW = 16;

    logic                 clk      = 1'b0;
    logic                 reset    = 1'b0;
    logic                 px_valid = 1'b0;
    logic                 px_sof   = 1'b0;
    logic                 px_eol   = 1'b0;
    logic signed [PW-1:0] px_a = '0, px_b = '0, px_c = '0;
    logic signed [PW-1:0] d1_a = '0, d1_b = '0, d1_c = '0;
    logic signed [PW-1:0] iA = '0, iB = '0, iC = '0;
    logic                 in_ready;
    logic                 o_valid;
    logic                 o_ready = 1'b0;
    logic [OW-1:0]        oR, oG, oB;
    logic                 o_sof, o_eol;
    logic [SW-1:0]        sat_cnt;
    logic                 err_ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc;
    int n_out;
    int stale;

    logic signed [PW-1:0] rnd_in  [5];
    logic [OW-1:0]        rnd_exp [5];

    always #5 clk = ~clk;

    // Multiplier model: products appear two clocks after the pixel.
    always @(posedge clk) begin
        d1_a <= px_a; d1_b <= px_b; d1_c <= px_c;
        iA   <= d1_a; iB   <= d1_b; iC   <= d1_c;
    end

    ccm_round_clamp dut (
        .clk      (clk),
        .reset    (reset),
        .px_valid (px_valid),
        .px_sof   (px_sof),
        .px_eol   (px_eol),
        .in_ready (in_ready),
        .iA       (iA),
        .iB       (iB),
        .iC       (iC),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .oR       (oR),
        .oG       (oG),
        .oB       (oB),
        .o_sof    (o_sof),
        .o_eol    (o_eol),
        .sat_cnt  (sat_cnt),
        .err_ovf  (err_ovf)
    );

    function automatic logic signed [PW-1:0] prod(input int v);
        return PW'(v);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic sof, input logic eol,
                         input logic signed [PW-1:0] a, input logic signed [PW-1:0] b,
                         input logic signed [PW-1:0] c);
        px_valid = v; px_sof = sof; px_eol = eol;
        px_a = a; px_b = b; px_c = c;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Waits (bounded) for an output pixel, checks it, and consumes it.
    task automatic expect_px(input string tag, input logic sof, input logic eol,
                             input logic [OW-1:0] r, input logic [OW-1:0] g,
                             input logic [OW-1:0] b);
        int n = 0;
        o_ready = 1'b1;
        while (!o_valid && n < 20) begin
            cycle();
            n++;
        end
        if (!o_valid)
            chk({tag, "_timeout"}, 64'(o_valid), 64'd1);
        else
            chk(tag, 64'({o_sof, o_eol, oR, oG, oB}), 64'({sof, eol, r, g, b}));
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        rnd_in[0] = prod(1536);  rnd_exp[0] = 10'd2;
        rnd_in[1] = prod(1535);  rnd_exp[1] = 10'd1;
        rnd_in[2] = prod(-512);  rnd_exp[2] = 10'd0;
        rnd_in[3] = prod(-1);    rnd_exp[3] = 10'd0;
        rnd_in[4] = prod(1023 * 1024 + 511); rnd_exp[4] = 10'd1023;

        repeat (3) cycle();
        chk("rst_o_valid", 64'(o_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_sat_cnt", 64'(sat_cnt), 64'd0);
        chk("rst_err_ovf", 64'(err_ovf), 64'd0);
        chk("rst_outputs", 64'({o_sof, o_eol, oR, oG, oB}), 64'd0);
        reset = 1'b1;
        repeat (2) cycle();

        // Identity path with exact latency.
        o_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b0, prod(300 * 1024), '0, prod(1023 * 1024));
        cycle();
        idle();
        cycle();
        cycle();
        chk("ident_not_early", 64'(o_valid), 64'd0);
        cycle();
        chk("ident_valid", 64'(o_valid), 64'd1);
        chk("ident_px", 64'({o_sof, o_eol, oR, oG, oB}), 64'({2'b00, 10'd300, 10'd0, 10'd1023}));
        cycle();
        chk("ident_popped", 64'(o_valid), 64'd0);
        chk("ident_sat_cnt", 64'(sat_cnt), 64'd0);

        // Rounding boundaries.
        o_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 1'b0, rnd_in[k], '0, '0);
            cycle();
        end
        idle();
        for (int k = 0; k < 5; k++)
            expect_px($sformatf("round%0d", k), 1'b0, 1'b0, rnd_exp[k], 10'd0, 10'd0);
        chk("round_no_sat", 64'(sat_cnt), 64'd0);

        // Saturation counting within a frame.
        o_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, prod(1024 * 1024), '0, '0);
        cycle();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b0, '0, prod(-5000), '0);
            cycle();
        end
        drive(1'b1, 1'b0, 1'b0, prod(5 * 1024), '0, '0);
        cycle();
        drive(1'b1, 1'b0, 1'b1, prod(5 * 1024), '0, '0);
        cycle();
        idle();
        repeat (5) cycle();
        chk("sat_cnt_4", 64'(sat_cnt), 64'd4);
        expect_px("sat_sof", 1'b1, 1'b0, 10'd1023, 10'd0, 10'd0);
        for (int k = 0; k < 3; k++)
            expect_px($sformatf("sat_neg%0d", k), 1'b0, 1'b0, 10'd0, 10'd0, 10'd0);
        expect_px("sat_clean0", 1'b0, 1'b0, 10'd5, 10'd0, 10'd0);
        expect_px("sat_clean1_eol", 1'b0, 1'b1, 10'd5, 10'd0, 10'd0);
        drive(1'b1, 1'b1, 1'b0, prod(7 * 1024), '0, '0);
        cycle();
        idle();
        expect_px("sof_clean", 1'b1, 1'b0, 10'd7, 10'd0, 10'd0);
        chk("sat_reload", 64'(sat_cnt), 64'd0);

        // Backpressure with a compliant source.
        o_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                drive(1'b1, 1'b0, 1'b0, prod((10 + n_acc) * 1024), '0, '0);
                n_acc++;
            end else begin
                idle();
            end
            cycle();
        end
        idle();
        chk("bp_accepted", 64'(n_acc), 64'd8);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        for (int k = 0; k < 8; k++)
            expect_px($sformatf("bp_out%0d", k), 1'b0, 1'b0, OW'(10 + k), 10'd0, 10'd0);
        chk("bp_in_ready_back", 64'(in_ready), 64'd1);
        chk("bp_drained", 64'(o_valid), 64'd0);

        // Steady state at one pixel per clock.
        o_ready = 1'b1;
        n_acc = 0;
        n_out = 0;
        for (int i = 0; i < 40; i++) begin
            if (i < 20 && in_ready) begin
                drive(1'b1, 1'b0, 1'b0, prod((i + 1) * 1024), '0, '0);
                n_acc++;
            end else begin
                idle();
            end
            if (o_valid) n_out++;
            cycle();
        end
        idle();
        chk("steady_accepted", 64'(n_acc), 64'd20);
        chk("steady_outputs", 64'(n_out), 64'd20);

        // Reset with five stored and two in flight.
        o_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, prod(2000 * 1024), '0, '0);
        cycle();
        for (int k = 1; k < 7; k++) begin
            drive(1'b1, 1'b0, 1'b0, prod((20 + k) * 1024), '0, '0);
            cycle();
        end
        idle();
        cycle();
        chk("pre_rst_sat", 64'(sat_cnt), 64'd1);
        chk("pre_rst_valid", 64'(o_valid), 64'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_o_valid", 64'(o_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_sat_cnt", 64'(sat_cnt), 64'd0);
        chk("mid_rst_outputs", 64'({o_sof, o_eol, oR, oG, oB}), 64'd0);
        cycle();
        reset = 1'b1;
        o_ready = 1'b1;
        stale = 0;
        repeat (10) begin
            cycle();
            if (o_valid) stale++;
        end
        chk("no_stale", 64'(stale), 64'd0);
        drive(1'b1, 1'b0, 1'b0, prod(42 * 1024), '0, '0);
        cycle();
        idle();
        expect_px("post_rst_px", 1'b0, 1'b0, 10'd42, 10'd0, 10'd0);

        // Forced overflow by a source ignoring in_ready.
        chk("ovf_clear", 64'(err_ovf), 64'd0);
        o_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 1'b0, 1'b0, prod((100 + k) * 1024), '0, '0);
            cycle();
        end
        idle();
        repeat (6) cycle();
        chk("ovf_set", 64'(err_ovf), 64'd1);
        chk("ovf_in_ready_low", 64'(in_ready), 64'd0);
        for (int k = 0; k < 8; k++)
            expect_px($sformatf("ovf_out%0d", k), 1'b0, 1'b0, OW'(100 + k), 10'd0, 10'd0);
        repeat (3) cycle();
        chk("ovf_no_extra", 64'(o_valid), 64'd0);
        chk("ovf_sticky", 64'(err_ovf), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ccm_round_clamp.md
Name: ccm_round_clamp

Overview:
Stage directly downstream of the 3x3 colour-correction matrix multiplier. It takes the three signed 38-bit row products and rounds away the coefficient fraction bits. It then clamps each product to the unsigned pixel range and buffers the results in a small FIFO. Its output is a valid/ready stream to the next ISP stage. It also issues credit-based in_ready to the pixel source feeding the multiplier, because the multiplier is free-running and cannot stall.

Parameters:
MULT_LAT, 2, clock latency of the upstream multiplier (pixel in to product out); >=1
FRAC_BITS, 10, fraction bits in the coefficients; >=1
PROD_W, 38, product width
OUT_W, 10, output pixel width per channel
DEPTH, 8, FIFO entries; must be >= MULT_LAT+3 for 1 px/clk
SAT_W, 16, saturation counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
px_valid  in  1  pixel presented at multiplier input this cycle
px_sof  in  1  start-of-frame tag, qualified by px_valid
px_eol  in  1  end-of-line tag, qualified by px_valid
in_ready  out  1  source may present a pixel to the multiplier this cycle
iA, iB, iC  in  PROD_W (signed)  multiplier row products, valid MULT_LAT cycles after acceptance
o_valid  out  1  output pixel available
o_ready  in  1  downstream accepts
oR, oG, oB  out  OUT_W  clamped channels (from iA, iB, iC)
o_sof, o_eol  out  1  tags aligned with the output pixel
sat_cnt  out  SAT_W  pixels in the current frame with any channel clamped
err_ovf  out  1  sticky: a write reached a full FIFO

Behaviour:
- Accept: px_valid && in_ready at cycle t. {valid, sof, eol} enter a MULT_LAT-deep shift register. The tail aligns with iA..iC at t+MULT_LAT.
- Round/clamp stage, registered, 1 cycle, per channel:
  - s = p + 2^(FRAC_BITS-1), computed at PROD_W+1 bits signed.
  - q = s >>> FRAC_BITS (arithmetic).
  - If q<0, output 0. If q>2^OUT_W-1, output 2^OUT_W-1. Otherwise output q[OUT_W-1:0].
  - Per-pixel flag sat = OR of the three channel clamp conditions.
- FIFO: synchronous, show-ahead. The clamp-stage output is written at t+MULT_LAT+1.
  - o_valid = !empty. The data/tags at the head drive the outputs.
  - Pop on o_valid && o_ready.
  - Latency with an empty FIFO: o_valid at t+MULT_LAT+2.
- Credit:
  - inflight = count of valid bits in the shift register plus the clamp stage.
  - in_ready = (fifo_count + inflight) < DEPTH, combinational from registered state. A same-cycle pop is not credited.
- Simultaneous push and pop on a full FIFO: the pop is honoured. The push is treated as a write to a full FIFO: it is dropped and err_ovf is set.
- Push with the FIFO full and no pop (protocol violation only): the write is dropped and err_ovf is set to 1 until reset.
- sat_cnt:
  - When a pixel with sof leaves the clamp stage, load sat_cnt with its sat flag (0 or 1).
  - Otherwise each clamped pixel increments sat_cnt, saturating at 2^SAT_W-1.
  - Updated when the pixel is written, not when it is output.
- Pointer wrap: pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Reset (any time, including mid-frame):
  - Clears the shift register, clamp stage, FIFO pointers/count, sat_cnt and err_ovf.
  - Outputs: o_valid=0, oR/oG/oB=0, o_sof=o_eol=0, in_ready=1.
  - In-flight pixels are discarded.

Decomposition:
- Package isp_ccm_pkg holds:
  - PROD_W=38, PIX_W=10, COEF_FRAC=10, MULT_LAT=2.
  - A packed struct for the FIFO word: {sof, eol, r, g, b}.
- One sub-module: isp_sync_fifo, parameterised on width and depth, with count output, show-ahead read and full/empty.
- The round/clamp function is defined once and instantiated per channel.

Test Plan:
- Identity path: iA=300*1024, iB=0, iC=1023*1024, o_ready=1 -> oR=300, oG=0, oB=1023 at t+4 (defaults); sat_cnt unchanged.
- Rounding: iA=1536 -> 2; iA=1535 -> 1; iA=-512 -> 0; iA=-1 -> 0; iA=1023*1024+511 -> 1023, no clamp flag.
- Saturation: sof pixel with iA=1024*1024, followed by 3 pixels iB=-5000, then 2 clean pixels -> oR=1023, oG=0; sat_cnt=4; the next sof pixel (clean) reloads sat_cnt=0.
- Backpressure: o_ready=0, px_valid held 1 -> exactly 8 pixels accepted, then in_ready=0. Release o_ready -> 8 outputs in order, no loss, in_ready reasserts; steady state with o_ready=1 sustains 1 px/clk.
- Reset mid-stream: FIFO holding 5 entries plus 2 in flight, reset pulsed low -> o_valid=0 and in_ready=1 immediately, sat_cnt=0, and no stale output after release.
- Forced overflow: drive px_valid ignoring in_ready with o_ready=0 -> err_ovf=1 stays set, FIFO contents are the first 8 pixels unchanged.
